// File: rtl/spi_regfile_pkg.sv
// Shared constants and state encoding for the SPI register-file slave.
package spi_regfile_pkg;

  localparam int CMD_W       = 8;
  localparam int ADDR_BYTE_W = 8;
  // Wide enough to count down from DATA_W-1 for DATA_W up to 32.
  localparam int CNT_W       = 5;

  localparam logic [CMD_W-1:0] GET_CODE = 8'h50;
  localparam logic [CMD_W-1:0] PUT_CODE = 8'h46;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    GET,
    PUT,
    DONE
  } state_t;

endpackage

// File: rtl/spi_regfile_slave_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin with registered edge flags.
// The edge flags are aligned with o_sync: in the cycle o_fall is high,
// o_sync has just gone from 1 to 0.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_sync,
  output logic o_fall,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_fall;
  logic r_rise;

  // Shift the pin through two flops; flag edges between stage two and stage one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_fall <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_fall <= r_sync & ~r_meta;
      r_rise <= ~r_sync & r_meta;
    end
  end

  assign o_sync = r_sync;
  assign o_fall = r_fall;
  assign o_rise = r_rise;

endmodule

// File: rtl/spi_regfile_slave.sv
// SPI slave exposing a bank of registers: 8-bit command, 8-bit address, then
// MSB-first data words with auto-incrementing bursts while CS stays low.
// A fabric write port shares the bank; SPI writes win on address collisions.
module spi_regfile_slave
  import spi_regfile_pkg::*;
#(
  parameter int               DATA_W    = 16,
  parameter int               ADDR_W    = 3,
  parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(16'hABCD)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           SCLK,
  input  logic                           CS,
  input  logic                           SDI,
  output logic                           SDO,
  input  logic                           fab_wr_en,
  input  logic [ADDR_W-1:0]              fab_wr_addr,
  input  logic [DATA_W-1:0]              fab_wr_data,
  output logic [(2**ADDR_W)*DATA_W-1:0]  regs_q,
  output logic                           spi_wr_stb,
  output logic [ADDR_W-1:0]              spi_wr_addr
);

  localparam int               NUM_REGS  = 2**ADDR_W;
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(CMD_W - 1);

  logic w_cs, w_cs_fall, w_cs_rise;
  logic w_sclk, w_sclk_fall, w_sclk_rise;
  logic w_sdi, w_sdi_fall, w_sdi_rise;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .i_d(SCLK),
    .o_sync(w_sclk), .o_fall(w_sclk_fall), .o_rise(w_sclk_rise)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .i_d(CS),
    .o_sync(w_cs), .o_fall(w_cs_fall), .o_rise(w_cs_rise)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sdi (
    .clk(clk), .rst(rst), .i_d(SDI),
    .o_sync(w_sdi), .o_fall(w_sdi_fall), .o_rise(w_sdi_rise)
  );

  state_t                  r_state, w_state_next;
  logic [CNT_W-1:0]        r_cnt, w_cnt_next;
  logic [CMD_W-1:0]        r_cmd_sh, w_cmd_sh_next;
  logic [ADDR_BYTE_W-1:0]  r_addr_sh, w_addr_sh_next;
  logic                    r_is_get, w_is_get_next;
  logic [ADDR_W-1:0]       r_addr, w_addr_next;
  logic [DATA_W-1:0]       r_data_sh, w_data_sh_next;
  logic                    r_sdo, w_sdo_next;
  logic                    r_wr_stb, w_wr_stb_next;
  logic [ADDR_W-1:0]       r_wr_addr, w_wr_addr_next;
  logic                    w_spi_we;
  logic [DATA_W-1:0]       w_spi_wdata;
  logic [DATA_W-1:0]       r_regs [NUM_REGS];

  logic [CMD_W-1:0]        w_cmd_full;
  logic [ADDR_BYTE_W-1:0]  w_addr_full;
  logic [DATA_W:0]         w_data_shift;
  logic [ADDR_W-1:0]       w_addr_inc;
  logic                    w_addr_bad;

  // Byte/word values as they will be once the current SDI bit is shifted in.
  assign w_cmd_full   = {r_cmd_sh[CMD_W-2:0], w_sdi};
  assign w_addr_full  = {r_addr_sh[ADDR_BYTE_W-2:0], w_sdi};
  assign w_data_shift = {r_data_sh, w_sdi};
  assign w_addr_inc   = r_addr + ADDR_W'(1);
  assign w_addr_bad   = (w_addr_full >> ADDR_W) != '0;

  // Edge flags of CS/SDI and the discarded shifter MSBs have no consumer.
  logic w_unused;
  assign w_unused = ^{w_sclk, w_sclk_rise, w_cs_fall, w_cs_rise, w_sdi_fall,
                      w_sdi_rise, r_cmd_sh[CMD_W-1], r_addr_sh[ADDR_BYTE_W-1],
                      w_data_shift[DATA_W]};

  // Next-state and datapath decisions; CS high overrides everything.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_cmd_sh_next  = r_cmd_sh;
    w_addr_sh_next = r_addr_sh;
    w_is_get_next  = r_is_get;
    w_addr_next    = r_addr;
    w_data_sh_next = r_data_sh;
    w_sdo_next     = r_sdo;
    w_wr_stb_next  = 1'b0;
    w_wr_addr_next = r_wr_addr;
    w_spi_we       = 1'b0;
    w_spi_wdata    = w_data_shift[DATA_W-1:0];

    if (w_cs) begin
      w_state_next   = IDLE;
      w_sdo_next     = 1'b1;
      w_cnt_next     = BYTE_LAST;
      w_cmd_sh_next  = '0;
      w_addr_sh_next = '0;
    end else begin
      case (r_state)
        IDLE: w_state_next = CMD;

        CMD: if (w_sclk_fall) begin
          w_cmd_sh_next = w_cmd_full;
          if (r_cnt == '0) begin
            w_cnt_next = BYTE_LAST;
            if (w_cmd_full == GET_CODE || w_cmd_full == PUT_CODE) begin
              w_state_next  = ADDR;
              w_is_get_next = (w_cmd_full == GET_CODE);
            end else begin
              w_state_next = DONE;
            end
          end else begin
            w_cnt_next = r_cnt - CNT_W'(1);
          end
        end

        ADDR: if (w_sclk_fall) begin
          w_addr_sh_next = w_addr_full;
          if (r_cnt == '0) begin
            if (w_addr_bad) begin
              w_state_next = DONE;
            end else begin
              w_addr_next = w_addr_full[ADDR_W-1:0];
              w_cnt_next  = WORD_LAST;
              if (r_is_get) begin
                w_data_sh_next = r_regs[w_addr_full[ADDR_W-1:0]];
                w_sdo_next     = w_data_sh_next[DATA_W-1];
                w_state_next   = GET;
              end else begin
                w_data_sh_next = '0;
                w_state_next   = PUT;
              end
            end
          end else begin
            w_cnt_next = r_cnt - CNT_W'(1);
          end
        end

        GET: if (w_sclk_fall) begin
          if (r_cnt == '0) begin
            // Word finished: move on and snapshot the next register.
            w_addr_next    = w_addr_inc;
            w_data_sh_next = r_regs[w_addr_inc];
            w_cnt_next     = WORD_LAST;
          end else begin
            w_data_sh_next = r_data_sh << 1;
            w_cnt_next     = r_cnt - CNT_W'(1);
          end
          w_sdo_next = w_data_sh_next[DATA_W-1];
        end

        PUT: if (w_sclk_fall) begin
          w_data_sh_next = w_data_shift[DATA_W-1:0];
          if (r_cnt == '0) begin
            w_spi_we       = 1'b1;
            w_wr_stb_next  = 1'b1;
            w_wr_addr_next = r_addr;
            w_addr_next    = w_addr_inc;
            w_cnt_next     = WORD_LAST;
          end else begin
            w_cnt_next = r_cnt - CNT_W'(1);
          end
        end

        DONE: w_sdo_next = 1'b1;

        default: w_state_next = IDLE;
      endcase
    end
  end

  // FSM state and SPI datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= BYTE_LAST;
      r_cmd_sh  <= '0;
      r_addr_sh <= '0;
      r_is_get  <= 1'b0;
      r_addr    <= '0;
      r_data_sh <= '0;
      r_sdo     <= 1'b1;
      r_wr_stb  <= 1'b0;
      r_wr_addr <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_cmd_sh  <= w_cmd_sh_next;
      r_addr_sh <= w_addr_sh_next;
      r_is_get  <= w_is_get_next;
      r_addr    <= w_addr_next;
      r_data_sh <= w_data_sh_next;
      r_sdo     <= w_sdo_next;
      r_wr_stb  <= w_wr_stb_next;
      r_wr_addr <= w_wr_addr_next;
    end
  end

  // Register bank: fabric write first so a colliding SPI commit overrides it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= RESET_VAL;
      end
    end else begin
      if (fab_wr_en) begin
        r_regs[fab_wr_addr] <= fab_wr_data;
      end
      if (w_spi_we) begin
        r_regs[r_addr] <= w_spi_wdata;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_flat
      assign regs_q[gi*DATA_W +: DATA_W] = r_regs[gi];
    end
  endgenerate

  assign SDO         = r_sdo;
  assign spi_wr_stb  = r_wr_stb;
  assign spi_wr_addr = r_wr_addr;

endmodule

// File: tb/tb_spi_regfile_slave.sv
// Self-checking bench: directed frames plus randomized frames checked
// against an array model of the register bank.
module tb_spi_regfile_slave;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NR = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              SCLK, CS, SDI, SDO;
  logic              fab_wr_en;
  logic [AW-1:0]     fab_wr_addr;
  logic [DW-1:0]     fab_wr_data;
  logic [NR*DW-1:0]  regs_q;
  logic              spi_wr_stb;
  logic [AW-1:0]     spi_wr_addr;

  always #5 clk = ~clk;

  spi_regfile_slave #(.DATA_W(DW), .ADDR_W(AW), .RESET_VAL(16'hABCD)) dut (
    .clk(clk), .rst(rst), .SCLK(SCLK), .CS(CS), .SDI(SDI), .SDO(SDO),
    .fab_wr_en(fab_wr_en), .fab_wr_addr(fab_wr_addr), .fab_wr_data(fab_wr_data),
    .regs_q(regs_q), .spi_wr_stb(spi_wr_stb), .spi_wr_addr(spi_wr_addr)
  );

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] model [NR];
  logic [DW-1:0] tx_w  [8];
  logic          smp   [128];
  int            stb_q [$];
  int            exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Strobe monitor: one entry per high cycle of spi_wr_stb.
  always @(negedge clk) begin
    if (!rst && spi_wr_stb) stb_q.push_back(int'(spi_wr_addr));
  end

  task automatic check_regs();
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("reg%0d", i), regs_q[i*DW +: DW], model[i]);
    end
  endtask

  task automatic fab_write(input int a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    fab_wr_en = 1'b1; fab_wr_addr = AW'(a); fab_wr_data = d;
    @(posedge clk); #1;
    fab_wr_en = 1'b0;
    model[a] = d;
    $display("fabric write addr=%0d data=%04h", a, d);
  endtask

  // Host side: SDI set with SCLK rise, slave samples on fall, SDO read at rise.
  task automatic frame(input logic [7:0] cmd, input logic [7:0] addr,
                       input int nbits, input int fab_bit);
    logic b;
    CS = 1'b0;
    repeat (4) @(posedge clk);
    for (int n = 0; n < nbits; n++) begin
      if (n < 8) b = cmd[7-n];
      else if (n < 16) b = addr[15-n];
      else begin
        int k, j;
        k = (n - 16) / 16;
        j = (n - 16) % 16;
        b = tx_w[k][15-j];
      end
      @(posedge clk); #1;
      SCLK = 1'b1; SDI = b; smp[n] = SDO;
      repeat (8) @(posedge clk); #1;
      SCLK = 1'b0;
      if (n == fab_bit) begin
        // The commit for this fall lands on the third clk edge after the pin.
        repeat (2) @(posedge clk); #1;
        fab_wr_en = 1'b1;
        @(posedge clk); #1;
        fab_wr_en = 1'b0;
        chk("stb_latency", spi_wr_stb, 1'b1);
        repeat (4) @(posedge clk);
      end else begin
        repeat (7) @(posedge clk);
      end
    end
    repeat (4) @(posedge clk); #1;
    CS = 1'b1;
    repeat (6) @(posedge clk); #1;
    chk("sdo_cs_high", SDO, 1'b1);
    $display("frame cmd=%02h addr=%02h bits=%0d", cmd, addr, nbits);
  endtask

  // Compare what the host saw against the frame rules and update the model.
  task automatic expect_frame(input logic [7:0] cmd, input logic [7:0] addr, input int nbits);
    int ones, full;
    logic [DW-1:0] w;
    bit valid;
    ones = 0;
    for (int n = 0; n < 16; n++) ones += int'(smp[n]);
    chk("hdr_sdo", ones, 16);
    valid = (addr < NR);
    full  = (nbits - 16) / 16;
    if (cmd == 8'h50 && valid) begin
      for (int k = 0; k < full; k++) begin
        for (int j = 0; j < 16; j++) w[15-j] = smp[16 + 16*k + j];
        chk("get_word", w, model[(int'(addr) + k) % NR]);
      end
    end else begin
      ones = 0;
      for (int n = 16; n < nbits; n++) ones += int'(smp[n]);
      chk("idle_sdo", ones, nbits - 16);
    end
    if (cmd == 8'h46 && valid) begin
      for (int k = 0; k < full; k++) begin
        model[(int'(addr) + k) % NR] = tx_w[k];
        exp_q.push_back((int'(addr) + k) % NR);
      end
    end
    chk("stb_cnt", stb_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      int e, g;
      e = exp_q.pop_front();
      g = (stb_q.size() > 0) ? stb_q.pop_front() : -1;
      chk("stb_addr", g, e);
    end
    stb_q.delete();
    check_regs();
  endtask

  initial begin
    rst = 1'b1; CS = 1'b1; SCLK = 1'b0; SDI = 1'b0;
    fab_wr_en = 1'b0; fab_wr_addr = '0; fab_wr_data = '0;
    for (int i = 0; i < NR; i++) model[i] = 16'hABCD;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_sdo", SDO, 1'b1);
    chk("rst_stb", spi_wr_stb, 1'b0);
    chk("rst_wr_addr", spi_wr_addr, 3'd0);
    check_regs();
    repeat (4) @(posedge clk);

    // GET addr 0
    frame(8'h50, 8'h00, 32, -1);
    expect_frame(8'h50, 8'h00, 32);

    // PUT addr 2
    tx_w[0] = 16'h1234;
    frame(8'h46, 8'h02, 32, -1);
    expect_frame(8'h46, 8'h02, 32);

    // Burst PUT wrapping 7 -> 0
    tx_w[0] = 16'h1111; tx_w[1] = 16'h2222;
    frame(8'h46, 8'h07, 48, -1);
    expect_frame(8'h46, 8'h07, 48);

    // Invalid command, then out-of-range address
    tx_w[0] = 16'h0F0F;
    frame(8'h55, 8'h00, 32, -1);
    expect_frame(8'h55, 8'h00, 32);
    frame(8'h50, 8'h08, 32, -1);
    expect_frame(8'h50, 8'h08, 32);

    // CS raised after 10 data bits, then a clean burst GET
    tx_w[0] = 16'h7E57;
    frame(8'h46, 8'h05, 26, -1);
    expect_frame(8'h46, 8'h05, 26);
    frame(8'h50, 8'h05, 48, -1);
    expect_frame(8'h50, 8'h05, 48);

    // Same-cycle fabric and SPI writes to the same address: SPI wins
    fab_wr_addr = 3'd3; fab_wr_data = 16'hBEEF;
    tx_w[0] = 16'h5555;
    frame(8'h46, 8'h03, 32, 31);
    model[3] = 16'hBEEF;
    expect_frame(8'h46, 8'h03, 32);

    // Different addresses in the same cycle: both land
    fab_write(3, 16'h0000);
    fab_wr_addr = 3'd4; fab_wr_data = 16'hBEEF;
    frame(8'h46, 8'h03, 32, 31);
    model[4] = 16'hBEEF;
    expect_frame(8'h46, 8'h03, 32);

    // Randomized frames with fabric writes in between
    for (int t = 0; t < 20; t++) begin
      logic [7:0] cmd, addr;
      int r, nwords, nbits;
      r = $urandom_range(0, 9);
      cmd = (r < 4) ? 8'h50 : (r < 8) ? 8'h46 : 8'($urandom);
      addr = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(0, 7));
      nwords = $urandom_range(1, 3);
      for (int k = 0; k < nwords; k++) tx_w[k] = 16'($urandom);
      nbits = 16 + 16 * nwords;
      if (cmd == 8'h46 && $urandom_range(0, 3) == 0) nbits -= $urandom_range(1, 15);
      frame(cmd, addr, nbits, -1);
      expect_frame(cmd, addr, nbits);
      if ($urandom_range(0, 1) == 1) begin
        fab_write($urandom_range(0, NR-1), 16'($urandom));
        repeat (2) @(posedge clk); #1;
        check_regs();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
